// File: rtl/acc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : acc_ctrl_fsm
// Purpose  : Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Revision : 1.0 - initial release
// ============================================================================
module acc_ctrl_fsm #(
    parameter int IMM_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             CLB,
    input  logic             run,
    input  logic [7:0]       instr,
    input  logic             mem_ready,
    input  logic             acc_zero,
    output logic             fetch_req,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [1:0]       SelAcc,
    output logic             loadAcc,
    output logic [2:0]       alu_op,
    output logic [IMM_W-1:0] rf_addr,
    output logic             rf_we,
    output logic [IMM_W-1:0] imm,
    output logic             halted,
    output logic             fault
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] C_WAIT_LIMIT = CNT_W'(WAIT_MAX);

    localparam logic [3:0] C_OP_NOP = 4'h0;
    localparam logic [3:0] C_OP_LDI = 4'h1;
    localparam logic [3:0] C_OP_LDR = 4'h2;
    localparam logic [3:0] C_OP_STR = 4'h3;
    localparam logic [3:0] C_OP_JMP = 4'hC;
    localparam logic [3:0] C_OP_JZ  = 4'hD;
    localparam logic [3:0] C_OP_ILL = 4'hE;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    localparam logic [1:0] C_SEL_ALU = 2'b00;
    localparam logic [1:0] C_SEL_RF  = 2'b01;
    localparam logic [1:0] C_SEL_IMM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_ALU_WB = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    logic [3:0]        w_opcode;
    logic [IMM_W-1:0]  w_operand;
    logic              w_is_alu;
    logic [2:0]        w_alu_code;
    logic [CNT_W-1:0]  w_cnt_inc;
    state_t            w_boundary;

    assign w_opcode   = ir_q[7:4];
    assign w_operand  = ir_q[IMM_W-1:0];
    assign w_is_alu   = (w_opcode >= 4'h4) && (w_opcode <= 4'hB);
    // Opcodes 4..B map onto ALU codes 0..7 by dropping the bias of 4.
    assign w_alu_code = w_opcode[2:0] - 3'd4;
    assign w_cnt_inc  = wait_cnt_q + CNT_W'(1);
    // Entry to FETCH is the only point where run is honoured.
    assign w_boundary = run ? S_FETCH : S_IDLE;

    assign halted = halted_q;
    assign fault  = fault_q;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_cnt_d = wait_cnt_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        fetch_req  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        SelAcc     = C_SEL_ALU;
        loadAcc    = 1'b0;
        alu_op     = 3'd0;
        rf_addr    = '0;
        rf_we      = 1'b0;
        imm        = '0;

        if ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_ALU_WB)) begin
            rf_addr = w_operand;
            imm     = w_operand;
            alu_op  = w_is_alu ? w_alu_code : 3'd0;
        end

        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (mem_ready) begin
                    ir_d       = instr;
                    pc_inc     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_DECODE;
                end else if (w_cnt_inc == C_WAIT_LIMIT) begin
                    wait_cnt_d = '0;
                    fault_d    = 1'b1;
                    halted_d   = 1'b1;
                    state_d    = S_HALT;
                end else begin
                    wait_cnt_d = w_cnt_inc;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = w_boundary;
                if (w_is_alu) begin
                    state_d = S_ALU_WB;
                end else begin
                    case (w_opcode)
                        C_OP_NOP: ;
                        C_OP_LDI: begin
                            SelAcc  = C_SEL_IMM;
                            loadAcc = 1'b1;
                        end
                        C_OP_LDR: begin
                            SelAcc  = C_SEL_RF;
                            loadAcc = 1'b1;
                        end
                        C_OP_STR: rf_we   = 1'b1;
                        C_OP_JMP: pc_load = 1'b1;
                        C_OP_JZ:  pc_load = acc_zero;
                        C_OP_ILL: begin
                            fault_d  = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        C_OP_HLT: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            S_ALU_WB: begin
                SelAcc  = C_SEL_ALU;
                loadAcc = 1'b1;
                state_d = w_boundary;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!CLB) begin
            state_q    <= S_IDLE;
            ir_q       <= 8'h00;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_ctrl_fsm
// Purpose  : Directed-vector bench for the accumulator control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       CLB, run, mem_ready, acc_zero;
    logic [7:0] instr;
    logic       fetch_req, pc_inc, pc_load, loadAcc, rf_we, halted, fault;
    logic [1:0] SelAcc;
    logic [2:0] alu_op;
    logic [3:0] rf_addr, imm;
    logic [19:0] outs;

    int n_vec = 0;
    int n_err = 0;

    acc_ctrl_fsm #(.IMM_W(4), .WAIT_MAX(15)) dut (
        .clk(clk), .CLB(CLB), .run(run), .instr(instr), .mem_ready(mem_ready),
        .acc_zero(acc_zero), .fetch_req(fetch_req), .pc_inc(pc_inc), .pc_load(pc_load),
        .SelAcc(SelAcc), .loadAcc(loadAcc), .alu_op(alu_op), .rf_addr(rf_addr),
        .rf_we(rf_we), .imm(imm), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign outs = {fetch_req, pc_inc, pc_load, SelAcc, loadAcc, alu_op,
                   rf_addr, rf_we, imm, halted, fault};

    typedef struct {
        logic [7:0] ins;
        logic       az;
        logic [1:0] sel;
        logic       ld;
        logic       we;
        logic       pl;
        logic [2:0] alu;
        logic       is_alu;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{8'h17, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}; // LDI 7
        tbl[1]  = '{8'h43, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}; // ADD r3
        tbl[2]  = '{8'h55, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1}; // SUB r5
        tbl[3]  = '{8'h8A, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1}; // XOR rA
        tbl[4]  = '{8'hB1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1}; // SHR
        tbl[5]  = '{8'h35, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}; // STR r5
        tbl[6]  = '{8'h29, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}; // LDR r9
        tbl[7]  = '{8'hD5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}; // JZ taken
        tbl[8]  = '{8'hD5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}; // JZ not taken
        tbl[9]  = '{8'hCA, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}; // JMP A
        tbl[10] = '{8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}; // NOP

        CLB = 1'b0; run = 1'b0; mem_ready = 1'b0; acc_zero = 1'b0; instr = 8'h00;
        tick(); tick();
        chk("rst_outs", 32'(outs), 32'd0);
        run = 1'b1; mem_ready = 1'b1;
        tick();
        chk("rst_run_ignored", 32'(outs), 32'd0);

        // Directed instruction table; each entry starts in a FETCH cycle.
        CLB = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            instr = tbl[i].ins; acc_zero = tbl[i].az; #1;
            chk($sformatf("fetch_req[%0d]", i), 32'(fetch_req), 32'd1);
            chk($sformatf("fetch_inc[%0d]", i), 32'(pc_inc), 32'd1);
            tick();
            chk($sformatf("dec_imm[%0d]", i), 32'(imm), 32'(tbl[i].ins[3:0]));
            chk($sformatf("dec_load[%0d]", i), 32'(loadAcc), 32'd0);
            tick();
            chk($sformatf("exec_sel[%0d]", i), 32'(SelAcc), 32'(tbl[i].sel));
            chk($sformatf("exec_load[%0d]", i), 32'(loadAcc), 32'(tbl[i].ld));
            chk($sformatf("exec_we[%0d]", i), 32'(rf_we), 32'(tbl[i].we));
            chk($sformatf("exec_pcload[%0d]", i), 32'(pc_load), 32'(tbl[i].pl));
            chk($sformatf("exec_alu[%0d]", i), 32'(alu_op), 32'(tbl[i].alu));
            chk($sformatf("exec_rf[%0d]", i), 32'(rf_addr), 32'(tbl[i].ins[3:0]));
            chk($sformatf("exec_inc[%0d]", i), 32'(pc_inc), 32'd0);
            if (tbl[i].is_alu) begin
                tick();
                chk($sformatf("wb_load[%0d]", i), 32'(loadAcc), 32'd1);
                chk($sformatf("wb_sel[%0d]", i), 32'(SelAcc), 32'd0);
                chk($sformatf("wb_alu[%0d]", i), 32'(alu_op), 32'(tbl[i].alu));
                chk($sformatf("wb_fetch[%0d]", i), 32'(fetch_req), 32'd0);
            end
            tick();
        end
        chk("back_in_fetch", 32'(fetch_req), 32'd1);

        // run dropped mid-instruction: instruction completes, then IDLE.
        instr = 8'h00;
        tick();
        run = 1'b0;
        tick();
        chk("rundrop_exec", 32'(fetch_req), 32'd0);
        tick();
        chk("rundrop_idle", 32'(outs), 32'd0);
        tick();
        chk("rundrop_stay", 32'(outs), 32'd0);
        run = 1'b1;
        tick();
        chk("rerun_fetch", 32'(fetch_req), 32'd1);

        // Reset asserted during ALU_WB.
        instr = 8'h55;
        tick(); tick(); tick();
        chk("mid_wb_load", 32'(loadAcc), 32'd1);
        CLB = 1'b0;
        tick();
        chk("mid_wb_reset", 32'(outs), 32'd0);
        CLB = 1'b1;
        tick();
        chk("post_rst_fetch", 32'(fetch_req), 32'd1);

        // Fetch timeout: 15 stalled FETCH cycles, HALT on the 16th.
        mem_ready = 1'b0; #1;
        chk("stall_no_inc", 32'(pc_inc), 32'd0);
        for (int k = 0; k < 14; k++) tick();
        chk("stall14_fetch", 32'(fetch_req), 32'd1);
        chk("stall14_nohalt", 32'(halted), 32'd0);
        tick();
        chk("timeout_halt", 32'(halted), 32'd1);
        chk("timeout_fault", 32'(fault), 32'd1);
        chk("timeout_nofetch", 32'(fetch_req), 32'd0);
        mem_ready = 1'b1; run = 1'b0; tick(); run = 1'b1; tick(); tick();
        chk("timeout_sticky", 32'({halted, fault, fetch_req, pc_inc}), 32'hC);
        CLB = 1'b0;
        tick();
        chk("timeout_clear", 32'(outs), 32'd0);

        // HLT then illegal opcode.
        CLB = 1'b1; instr = 8'hF0;
        tick(); tick(); tick();
        chk("hlt_exec_nohalt", 32'(halted), 32'd0);
        tick();
        chk("hlt_halted", 32'({halted, fault}), 32'h2);
        run = 1'b0; tick(); run = 1'b1; tick();
        chk("hlt_sticky", 32'({halted, fault, fetch_req}), 32'h4);
        CLB = 1'b0; tick();
        CLB = 1'b1; instr = 8'hE3;
        tick(); tick(); tick(); tick();
        chk("ill_halt_fault", 32'({halted, fault}), 32'h3);
        chk("ill_no_pulse", 32'({pc_inc, pc_load, loadAcc, rf_we}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
